// File: rtl/call_stack_pkg.sv
// Shared CPU constants and the call-stack operation decode.
// Pure declarations; no state, no latency, no backpressure.
package call_stack_pkg;

  localparam int PC_WIDTH    = 12;
  localparam int STACK_DEPTH = 8;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE
  } stack_op_e;

  // push+pop on an empty stack degrades to a plain push (no underflow).
  function automatic stack_op_e decode_op(input logic push, input logic pop, input logic empty);
    if (push && pop && !empty) return OP_REPLACE;
    if (push)                  return OP_PUSH;
    if (pop)                   return OP_POP;
    return OP_NONE;
  endfunction

endpackage

// File: rtl/stack_ram.sv
// Return-address storage: one synchronous write port, one asynchronous read port.
// Write lands one cycle after we; read is combinational; never stalls.
module stack_ram #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/call_stack.sv
// Return-address stack with checkpoint/restore for speculative paths; 1-cycle update.
// No backpressure: pushes when full wrap or are dropped, pops when empty are dropped; flags are sticky.
module call_stack
  import call_stack_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int DEPTH = STACK_DEPTH,
  parameter bit WRAP  = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       ckpt,
  input  logic                       restore,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] SP_RST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [AW-1:0]    sp, sp_n, snap_sp, waddr;
  logic [CW-1:0]    cnt_n, snap_cnt;
  logic             we, ovf_set, unf_set;
  logic [WIDTH-1:0] rdata;
  stack_op_e        op;

  assign empty = (count == '0);
  assign full  = (count == CNT_MAX);
  assign top   = empty ? '0 : rdata;
  assign op    = decode_op(push, pop, empty);

  always_comb begin
    sp_n    = sp;
    cnt_n   = count;
    we      = 1'b0;
    waddr   = sp + 1'b1;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (en) begin
      if (restore) begin
        sp_n  = snap_sp;
        cnt_n = snap_cnt;
      end else begin
        unique case (op)
          OP_REPLACE: begin
            we    = 1'b1;
            waddr = sp;
          end
          OP_PUSH: begin
            if (!full) begin
              we    = 1'b1;
              sp_n  = sp + 1'b1;
              cnt_n = count + 1'b1;
            end else begin
              // Full: the slot above sp is the oldest entry when wrapping.
              ovf_set = 1'b1;
              if (WRAP) begin
                we   = 1'b1;
                sp_n = sp + 1'b1;
              end
            end
          end
          OP_POP: begin
            if (!empty) begin
              sp_n  = sp - 1'b1;
              cnt_n = count - 1'b1;
            end else begin
              unf_set = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp        <= SP_RST;
      count     <= '0;
      snap_sp   <= SP_RST;
      snap_cnt  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      sp        <= sp_n;
      count     <= cnt_n;
      overflow  <= overflow | ovf_set;
      underflow <= underflow | unf_set;
      // Snapshot captures the post-update pointer; restore wins over ckpt.
      if (en && ckpt && !restore) begin
        snap_sp  <= sp_n;
        snap_cnt <= cnt_n;
      end
    end
  end

  stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (push_data),
    .raddr (sp),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_call_stack.sv
// Directed bench for call_stack: default instance plus DEPTH=4 instances with and without wrap.
module tb_call_stack;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b1;
  logic        push = 1'b0;
  logic [11:0] push_data = '0;
  logic        pop = 1'b0;
  logic        ckpt = 1'b0;
  logic        restore = 1'b0;

  logic [11:0] a_top, b_top, c_top;
  logic [3:0]  a_count;
  logic [2:0]  b_count, c_count;
  logic        a_empty, a_full, a_ovf, a_unf;
  logic        b_empty, b_full, b_ovf, b_unf;
  logic        c_empty, c_full, c_ovf, c_unf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  call_stack u_a (
    .clk(clk), .rst(rst), .en(en), .push(push), .push_data(push_data), .pop(pop),
    .ckpt(ckpt), .restore(restore), .top(a_top), .count(a_count), .empty(a_empty),
    .full(a_full), .overflow(a_ovf), .underflow(a_unf)
  );

  call_stack #(.WIDTH(12), .DEPTH(4), .WRAP(1'b0)) u_b (
    .clk(clk), .rst(rst), .en(en), .push(push), .push_data(push_data), .pop(pop),
    .ckpt(ckpt), .restore(restore), .top(b_top), .count(b_count), .empty(b_empty),
    .full(b_full), .overflow(b_ovf), .underflow(b_unf)
  );

  call_stack #(.WIDTH(12), .DEPTH(4), .WRAP(1'b1)) u_c (
    .clk(clk), .rst(rst), .en(en), .push(push), .push_data(push_data), .pop(pop),
    .ckpt(ckpt), .restore(restore), .top(c_top), .count(c_count), .empty(c_empty),
    .full(c_full), .overflow(c_ovf), .underflow(c_unf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [11:0] d);
    push = 1'b1; push_data = d;
    step();
    push = 1'b0;
  endtask

  task automatic do_pop();
    pop = 1'b1;
    step();
    pop = 1'b0;
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b0;
    #1;
    check("rst_async_count", 32'(a_count), 0);
    check("rst_async_empty", 32'(a_empty), 1);
    check("rst_async_top", 32'(a_top), 0);
    #1 rst = 1'b1;
  endtask

  initial begin
    // Reset state, before any clock edge
    #2;
    check("reset_count", 32'(a_count), 0);
    check("reset_empty", 32'(a_empty), 1);
    check("reset_full", 32'(a_full), 0);
    check("reset_top", 32'(a_top), 0);
    check("reset_ovf", 32'(a_ovf), 0);
    check("reset_unf", 32'(a_unf), 0);
    #1 rst = 1'b1;

    // Basic push/pop
    do_push(12'h010);
    do_push(12'h020);
    do_push(12'h030);
    check("push3_top", 32'(a_top), 32'h030);
    check("push3_count", 32'(a_count), 3);
    do_pop();
    check("pop1_top", 32'(a_top), 32'h020);
    do_pop();
    check("pop2_top", 32'(a_top), 32'h010);
    do_pop();
    check("pop3_top", 32'(a_top), 0);
    check("pop3_empty", 32'(a_empty), 1);
    check("pop3_unf", 32'(a_unf), 0);

    // Push+pop replace, then underflow
    do_push(12'h044);
    push = 1'b1; pop = 1'b1; push_data = 12'h055;
    step();
    push = 1'b0; pop = 1'b0;
    check("repl_count", 32'(a_count), 1);
    check("repl_top", 32'(a_top), 32'h055);
    do_pop();
    check("repl_pop_empty", 32'(a_empty), 1);
    do_pop();
    check("underflow_set", 32'(a_unf), 1);
    check("underflow_top", 32'(a_top), 0);
    check("underflow_count", 32'(a_count), 0);
    do_push(12'h066);
    check("underflow_sticky", 32'(a_unf), 1);
    pulse_reset();
    check("underflow_cleared", 32'(a_unf), 0);

    // Push+pop on empty acts as a push
    push = 1'b1; pop = 1'b1; push_data = 12'h077;
    step();
    push = 1'b0; pop = 1'b0;
    check("pp_empty_count", 32'(a_count), 1);
    check("pp_empty_top", 32'(a_top), 32'h077);
    check("pp_empty_unf", 32'(a_unf), 0);
    pulse_reset();

    // Checkpoint / restore
    do_push(12'h100);
    do_push(12'h200);
    ckpt = 1'b1;
    step();
    ckpt = 1'b0;
    do_pop();
    check("ckpt_pop_top", 32'(a_top), 32'h100);
    do_push(12'h300);
    do_pop();
    check("spec_pop_count", 32'(a_count), 1);
    restore = 1'b1; push = 1'b1; push_data = 12'h3FF;
    step();
    restore = 1'b0; push = 1'b0;
    check("restore_count", 32'(a_count), 2);
    check("restore_top", 32'(a_top), 32'h300);

    // Stall: en low with push held
    en = 1'b0; push = 1'b1; push_data = 12'hABC;
    repeat (3) step();
    check("stall_count", 32'(a_count), 2);
    check("stall_top", 32'(a_top), 32'h300);
    push = 1'b0; en = 1'b1;

    // Mid-sequence reset, then restore without ckpt
    push = 1'b1; push_data = 12'h123;
    pulse_reset();
    push = 1'b0;
    check("post_rst_count", 32'(a_count), 0);
    do_push(12'h007);
    check("post_rst_push_count", 32'(a_count), 1);
    restore = 1'b1;
    step();
    restore = 1'b0;
    check("restore_nockpt_count", 32'(a_count), 0);
    check("restore_nockpt_empty", 32'(a_empty), 1);

    // DEPTH=4: WRAP=0 (u_b) and WRAP=1 (u_c) on the same stimulus
    pulse_reset();
    for (int i = 1; i <= 4; i++) do_push(12'(i));
    check("d4_full_b", 32'(b_full), 1);
    check("d4_ovf_b_before", 32'(b_ovf), 0);
    do_push(12'h005);
    check("nowrap_full", 32'(b_full), 1);
    check("nowrap_ovf", 32'(b_ovf), 1);
    check("nowrap_top", 32'(b_top), 4);
    check("nowrap_count", 32'(b_count), 4);
    check("wrap_count", 32'(c_count), 4);
    check("wrap_ovf", 32'(c_ovf), 1);
    check("wrap_top", 32'(c_top), 5);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("nowrap_pop%0d", i), 32'(b_top), 32'(4 - i));
      check($sformatf("wrap_pop%0d", i), 32'(c_top), 32'(5 - i));
      do_pop();
    end
    check("nowrap_final_empty", 32'(b_empty), 1);
    check("wrap_final_empty", 32'(c_empty), 1);
    check("nowrap_unf", 32'(b_unf), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
